byte_2_word: RTL and testbench
==============================

Name: byte_2_word

Overview:
Reassembles a stream of byte transfers into 16-bit words: low byte first, then high byte. This is the inverse of the existing word-to-byte serializer and sits on the receive side of the same 8-bit link, feeding the CPU's 16-bit data path. A two-state FSM pairs the bytes. A timeout counter discards an orphaned low byte so the pairing resynchronises after a dropped byte.

Parameters:
TIMEOUT_CYC, 4, number of ce-qualified cycles allowed in WAIT_HI without a byte before the low byte is discarded; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
ce  in  1  clock enable; when 0 all state holds and inputs are ignored
byte_dv  in  1  byte valid strobe, one cycle per byte
byte  in  8  byte data, sampled when byte_dv=1 and ce=1
word_dv  out  1  one-cycle pulse, word valid
word  out  16  assembled word {high, low}; holds until the next completion
busy  out  1  1 while in WAIT_HI (low byte held)
err_timeout  out  1  one-cycle pulse when a low byte is discarded

Behaviour:
- Reset (rst=0, async): state=IDLE, low_reg=0x00, cnt=0, word=0x0000, word_dv=0, err_timeout=0, busy=0.
- All outputs are registered. busy is decoded from the state register.
- A "take" is byte_dv=1 and ce=1 in the same cycle.
- IDLE:
  - On a take: low_reg<=byte, cnt<=0, go to WAIT_HI.
  - Otherwise remain in IDLE.
- WAIT_HI:
  - On a take: word<={byte, low_reg}, word_dv<=1 on the next edge, go to IDLE.
  - Else if ce=1 and TIMEOUT_CYC!=0:
    - cnt<=cnt+1.
    - If cnt==TIMEOUT_CYC-1: err_timeout<=1, go to IDLE, low_reg kept but unused.
- Latency: word_dv rises on the clk edge after the cycle that sampled the high byte (1 cycle). Back-to-back byte pairs yield one word every 2 takes with no dead cycle.
- Byte arriving on the timeout cycle: the byte wins and is used as the high byte; no err_timeout.
- Byte arriving in IDLE in the cycle after a timeout is treated as a new low byte.
- ce=0:
  - FSM, cnt, low_reg and word hold.
  - word_dv and err_timeout are driven 0, so pulses are never stretched.
  - cnt does not advance.
- word_dv and err_timeout are never both 1.
- cnt width: clog2(TIMEOUT_CYC+1), minimum 1 bit; no wrap occurs because the timeout fires first.
- Reset mid-pair: the partial low byte is lost; there is no word_dv and no err_timeout on exit from reset.
- A continuous byte_dv=1 with ce=1 is valid and alternates low/high every cycle.

Decomposition:
- Shared package/include holds:
  - state encoding constants (ST_IDLE=1'b0, ST_WAIT_HI=1'b1);
  - byte-order constant LOW_FIRST=1, also used by the word-to-byte serializer so both ends agree.
- No sub-module: the FSM, timeout counter and output registers live in one module (~150 lines).

Test Plan:
- Reset: hold rst=0 for 3 cycles with byte_dv toggling -> word=0x0000, word_dv=0, busy=0, err_timeout=0; release and confirm there is no spurious pulse.
- Pair: take 0x34 then 0x12 on consecutive cycles -> exactly one word_dv pulse one cycle after 0x12, word=0x1234, busy high for exactly 1 cycle.
- Round trip: the word-to-byte serializer drives this block with words 0xA55A, 0x00FF, 0xFFFF back-to-back -> three word_dv pulses with identical values in order, no err_timeout.
- Timeout: take 0x77, then idle 4 ce cycles (TIMEOUT_CYC=4) -> err_timeout pulse on the 4th, busy falls. Next pair 0xCD, 0xAB -> word=0xABCD.
- Boundary: take 0x11, idle 3 cycles, take 0x22 on the 4th (timeout) cycle -> word=0x2211, no err_timeout.
- ce gating: take 0x01, drop ce for 10 cycles (byte_dv=1 with 0xEE) -> no timeout, busy stays 1. Restore ce, take 0x02 -> word=0x0201. Drop ce in the cycle after completion -> word_dv=0.

Source files
------------

// File: rtl/byte_2_word_pkg.sv
// Shared definitions for the 8-bit link byte/word converters.
// Both ends of the link import the byte order from here so they always agree.
package byte_2_word_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // The first byte on the link carries the low half of the word.
  localparam bit LOW_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_HI = 1'b1
  } b2w_state_t;

  // Combine the first and second byte of a pair into a word.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] first_byte,
                                                  input logic [BYTE_W-1:0] second_byte);
    if (LOW_FIRST) pack_word = {second_byte, first_byte};
    else           pack_word = {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/byte_2_word_if.sv
// Byte-in / word-out handshake bundle of the byte-to-word reassembler.
// master drives the byte stream, slave is the reassembler.
interface byte_2_word_if;
  import byte_2_word_pkg::*;

  logic              ce;
  logic              byte_dv;
  logic [BYTE_W-1:0] byte_data;
  logic              word_dv;
  logic [WORD_W-1:0] word;
  logic              busy;
  logic              err_timeout;

  modport master (
    output ce, byte_dv, byte_data,
    input  word_dv, word, busy, err_timeout
  );

  modport slave (
    input  ce, byte_dv, byte_data,
    output word_dv, word, busy, err_timeout
  );

endinterface

// File: rtl/byte_2_word.sv
// Reassembles low/high byte pairs from the 8-bit link into 16-bit words.
// An orphaned low byte is dropped after TIMEOUT_CYC idle ce-cycles so pairing resynchronises.
module byte_2_word
  import byte_2_word_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  byte_2_word_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC <= 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_LAST_INT = (TIMEOUT_CYC <= 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);

  b2w_state_t        state;
  logic [BYTE_W-1:0] low_reg;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] word_q;
  logic              word_dv_q;
  logic              err_timeout_q;
  logic              take;

  assign take = bus.ce & bus.byte_dv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      low_reg       <= '0;
      cnt           <= '0;
      word_q        <= '0;
      word_dv_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      // Pulses default low every cycle, so a ce=0 cycle never stretches them.
      word_dv_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      if (bus.ce) begin
        unique case (state)
          ST_IDLE: begin
            if (take) begin
              low_reg <= bus.byte_data;
              cnt     <= '0;
              state   <= ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (take) begin
              word_q    <= pack_word(low_reg, bus.byte_data);
              word_dv_q <= 1'b1;
              state     <= ST_IDLE;
            end else if (TIMEOUT_CYC != 0) begin
              // A byte on the final cycle takes the branch above, so it wins over the timeout.
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                err_timeout_q <= 1'b1;
                state         <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.word        = word_q;
  assign bus.word_dv     = word_dv_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.busy        = (state == ST_WAIT_HI);

endmodule

// File: tb/tb_byte_2_word.sv
// Directed and randomized bench for byte_2_word, checked against a pairing model
// that tracks "is a low byte pending, and for how long" in plain integer terms.
module tb_byte_2_word;
  import byte_2_word_pkg::*;

  localparam int TO = 4;

  logic clk;
  logic rst;
  byte_2_word_if bus ();

  byte_2_word #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_have_low;
  logic [7:0]  m_low;
  int          m_idle;
  logic [15:0] m_word;
  logic        m_wdv;
  logic        m_err;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have_low = 1'b0;
    m_low      = 8'h00;
    m_idle     = 0;
    m_word     = 16'h0000;
    m_wdv      = 1'b0;
    m_err      = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic ce, input logic dv, input logic [7:0] d);
    m_wdv = 1'b0;
    m_err = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (ce) begin
      if (dv) begin
        if (m_have_low) begin
          m_word     = {d, m_low};
          m_wdv      = 1'b1;
          m_have_low = 1'b0;
        end else begin
          m_have_low = 1'b1;
          m_low      = d;
          m_idle     = 0;
        end
      end else if (m_have_low) begin
        m_idle++;
        if (m_idle == TO) begin
          m_have_low = 1'b0;
          m_err      = 1'b1;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance past the edge, compare against the model.
  task automatic cycle(input logic ce, input logic dv, input logic [7:0] d);
    bus.ce        = ce;
    bus.byte_dv   = dv;
    bus.byte_data = d;
    model_step(ce, dv, d);
    @(posedge clk);
    #1;
    chk("word", bus.word, m_word);
    chk("word_dv", 16'(bus.word_dv), 16'(m_wdv));
    chk("busy", 16'(bus.busy), 16'(m_have_low));
    chk("err_timeout", 16'(bus.err_timeout), 16'(m_err));
    chk("dv_err_excl", 16'(bus.word_dv & bus.err_timeout), 16'h0);
    if (bus.word_dv === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", bus.word, 16'hxxxx);
      else chk("sb_word_order", bus.word, exp_q.pop_front());
    end
  endtask

  initial begin
    bus.ce        = 1'b0;
    bus.byte_dv   = 1'b0;
    bus.byte_data = 8'h00;
    rst = 1'b0;
    model_reset();

    // Reset held with byte_dv toggling
    for (int i = 0; i < 3; i++) cycle(1'b1, i[0], 8'h5A);
    chk("rst_word", bus.word, 16'h0000);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00);
    chk("post_rst_dv", 16'(bus.word_dv), 16'h0);
    chk("post_rst_err", 16'(bus.err_timeout), 16'h0);

    // Simple pair
    exp_q.push_back(16'h1234);
    cycle(1'b1, 1'b1, 8'h34);
    chk("pair_busy1", 16'(bus.busy), 16'h1);
    cycle(1'b1, 1'b1, 8'h12);
    chk("pair_dv", 16'(bus.word_dv), 16'h1);
    chk("pair_word", bus.word, 16'h1234);
    chk("pair_busy0", 16'(bus.busy), 16'h0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("pair_dv_once", 16'(bus.word_dv), 16'h0);

    // Round trip: serializer-style back-to-back bytes, low first
    begin
      logic [15:0] rt [3];
      rt[0] = 16'hA55A; rt[1] = 16'h00FF; rt[2] = 16'hFFFF;
      for (int w = 0; w < 3; w++) begin
        exp_q.push_back(rt[w]);
        cycle(1'b1, 1'b1, rt[w][7:0]);
        cycle(1'b1, 1'b1, rt[w][15:8]);
        chk("rt_word", bus.word, rt[w]);
        chk("rt_dv", 16'(bus.word_dv), 16'h1);
      end
    end

    // Timeout on the 4th idle cycle, then resynchronised pair
    cycle(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    chk("to_pre_err", 16'(bus.err_timeout), 16'h0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("to_err", 16'(bus.err_timeout), 16'h1);
    chk("to_busy", 16'(bus.busy), 16'h0);
    exp_q.push_back(16'hABCD);
    cycle(1'b1, 1'b1, 8'hCD);
    cycle(1'b1, 1'b1, 8'hAB);
    chk("to_next_word", bus.word, 16'hABCD);

    // Byte on the timeout cycle wins
    exp_q.push_back(16'h2211);
    cycle(1'b1, 1'b1, 8'h11);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h22);
    chk("bnd_word", bus.word, 16'h2211);
    chk("bnd_err", 16'(bus.err_timeout), 16'h0);

    // ce gating
    exp_q.push_back(16'h0201);
    cycle(1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'hEE);
    chk("ce_busy", 16'(bus.busy), 16'h1);
    chk("ce_err", 16'(bus.err_timeout), 16'h0);
    cycle(1'b1, 1'b1, 8'h02);
    chk("ce_word", bus.word, 16'h0201);
    cycle(1'b0, 1'b0, 8'h00);
    chk("ce_dv_drop", 16'(bus.word_dv), 16'h0);
    chk("ce_word_hold", bus.word, 16'h0201);

    // Reset mid-pair loses the low byte without any pulse
    cycle(1'b1, 1'b1, 8'h55);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 16'(bus.busy), 16'h0);
    cycle(1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00);
    chk("midrst_dv", 16'(bus.word_dv), 16'h0);
    chk("midrst_err", 16'(bus.err_timeout), 16'h0);

    // Randomized traffic with bursts, gaps and ce drop-outs
    for (int i = 0; i < 600; i++) begin
      logic       ce_r, dv_r;
      logic [7:0] d_r;
      ce_r = ($urandom_range(0, 7) != 0);
      if (((i / 40) % 2) == 0) dv_r = ($urandom_range(0, 3) != 0);
      else                     dv_r = ($urandom_range(0, 5) == 0);
      d_r = 8'($urandom);
      if (ce_r && dv_r && rst) begin
        if (m_have_low) exp_q.push_back({d_r, m_low});
      end
      cycle(ce_r, dv_r, d_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
